// File: rtl/conv_pkg.sv
// Purpose: shared constants, FSM state encoding and the bank address helper
//          for the convolution scheduler.
// Contents:
//   BANK_DEPTH / NUM_BANKS / ADDR_W / IDX_W - frame geometry and widths
//   state_t                                  - scheduler FSM states
//   bank_addr()                              - index + k*BANK_DEPTH
package conv_pkg;

  localparam int BANK_DEPTH = 11520;
  localparam int NUM_BANKS  = 5;
  localparam int ADDR_W     = 16;
  localparam int IDX_W      = 14;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    FIRE,
    WAIT_DONE
  } state_t;

  // Largest result is 4*11520 + 11519 = 57599, which fits in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [IDX_W-1:0] idx,
                                                  input int               k);
    return ADDR_W'(idx) + ADDR_W'(k * BANK_DEPTH);
  endfunction

endpackage

// File: rtl/conv_scheduler_addr_gen.sv
// Purpose: holds the current pixel index and the five registered bank
//          addresses derived from it (bank k reads index + k*BANK_DEPTH).
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   i_clr            - load index with 0 (takes priority over i_inc)
//   i_inc            - advance index by one
//   o_index          - current pixel index
//   o_a1 .. o_a5     - bank addresses for banks 0..4
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [IDX_W-1:0]  o_index,
  output logic [ADDR_W-1:0] o_a1,
  output logic [ADDR_W-1:0] o_a2,
  output logic [ADDR_W-1:0] o_a3,
  output logic [ADDR_W-1:0] o_a4,
  output logic [ADDR_W-1:0] o_a5
);

  logic [IDX_W-1:0]  r_index;
  logic [ADDR_W-1:0] r_addr [NUM_BANKS];
  logic [IDX_W-1:0]  w_index_n;

  // The addresses are computed from the next index so they are valid in
  // the same cycle the new index becomes visible.
  always_comb begin
    w_index_n = r_index;
    if (i_clr) begin
      w_index_n = '0;
    end else if (i_inc) begin
      w_index_n = r_index + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index <= '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
        r_addr[k] <= bank_addr('0, k);
      end
    end else if (i_clr || i_inc) begin
      r_index <= w_index_n;
      for (int k = 0; k < NUM_BANKS; k++) begin
        r_addr[k] <= bank_addr(w_index_n, k);
      end
    end
  end

  assign o_index = r_index;
  assign o_a1    = r_addr[0];
  assign o_a2    = r_addr[1];
  assign o_a3    = r_addr[2];
  assign o_a4    = r_addr[3];
  assign o_a5    = r_addr[4];

endmodule

// File: rtl/conv_scheduler.sv
// Purpose: steps one frame of pixels through the 5-bank convolution
//          datapath: read strobe, memory latency wait, engine fire, wait
//          for engine done, advance.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   start          - frame start request (looked at in IDLE only)
//   abort          - synchronous abort, highest priority
//   conv_done      - engine finished current pixel (1-cycle pulse)
//   conv_start     - 1-cycle pulse firing the engine
//   mem_en         - 1-cycle bank read strobe
//   a1 .. a5       - bank addresses, index + k*BANK_DEPTH
//   cur_index      - current pixel index
//   busy           - high in every state except IDLE
//   pass           - 1-cycle pulse after the last pixel completes
//   err_spurious   - sticky: conv_done arrived outside WAIT_DONE
//   dbg_state      - current FSM state
//
// Engine handshake: conv_start and conv_done are both single-cycle pulses.
// One conv_start is issued per pixel; the scheduler then waits any number
// of cycles for exactly one conv_done. A conv_done in any state other than
// WAIT_DONE is not consumed and only raises err_spurious.
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int MEM_LAT = 1
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              conv_done,
  output logic              conv_start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic [ADDR_W-1:0] a3,
  output logic [ADDR_W-1:0] a4,
  output logic [ADDR_W-1:0] a5,
  output logic [IDX_W-1:0]  cur_index,
  output logic              busy,
  output logic              pass,
  output logic              err_spurious,
  output state_t            dbg_state
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  state_t           r_state;
  state_t           w_state_n;
  logic [2:0]       r_lat_cnt;
  logic [2:0]       w_lat_n;
  logic             r_conv_start;
  logic             r_mem_en;
  logic             r_busy;
  logic             r_pass;
  logic             r_err;
  logic             w_clr;
  logic             w_inc;
  logic             w_pass_n;
  logic             w_last;
  logic [IDX_W-1:0] w_index;

  assign w_last = (w_index == IDX_W'(BANK_DEPTH - 1));

  always_comb begin
    w_state_n = r_state;
    w_lat_n   = r_lat_cnt;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    w_pass_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = FETCH;
          w_clr     = 1'b1;
        end
      end
      FETCH: begin
        w_lat_n   = LAT_LOAD;
        w_state_n = (MEM_LAT == 0) ? FIRE : WAIT_MEM;
      end
      WAIT_MEM: begin
        // Counter was loaded with MEM_LAT, so this state lasts MEM_LAT cycles.
        if (r_lat_cnt <= 3'd1) begin
          w_state_n = FIRE;
        end else begin
          w_lat_n = r_lat_cnt - 3'd1;
        end
      end
      FIRE: begin
        w_state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_done) begin
          if (w_last) begin
            w_clr     = 1'b1;
            w_pass_n  = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_inc     = 1'b1;
            w_state_n = FETCH;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
    // Abort overrides start and conv_done in the same cycle.
    if (abort) begin
      w_state_n = IDLE;
      w_clr     = 1'b1;
      w_inc     = 1'b0;
      w_pass_n  = 1'b0;
    end
  end

  // Strobes are decoded from the next state so they are registered yet
  // coincide exactly with the cycle spent in FETCH / FIRE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_conv_start <= 1'b0;
      r_mem_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_lat_cnt    <= w_lat_n;
      r_conv_start <= (w_state_n == FIRE);
      r_mem_en     <= (w_state_n == FETCH);
      r_busy       <= (w_state_n != IDLE);
      r_pass       <= w_pass_n;
      r_err        <= r_err | (conv_done && (r_state != WAIT_DONE));
    end
  end

  conv_addr_gen u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_index (w_index),
    .o_a1    (a1),
    .o_a2    (a2),
    .o_a3    (a3),
    .o_a4    (a4),
    .o_a5    (a5)
  );

  assign conv_start   = r_conv_start;
  assign mem_en       = r_mem_en;
  assign cur_index    = w_index;
  assign busy         = r_busy;
  assign pass         = r_pass;
  assign err_spurious = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=0.
// A timing-based model (cycles since read strobe per pixel) predicts every
// output each cycle; directed sections pin the model with literal values.
module tb_conv_scheduler;
  import conv_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              start;
  logic              abort;
  logic [1:0]        done;
  logic [1:0]        conv_start;
  logic [1:0]        mem_en;
  logic [1:0]        busy;
  logic [1:0]        pass;
  logic [1:0]        err;
  logic [ADDR_W-1:0] a [2][NUM_BANKS];
  logic [IDX_W-1:0]  cur_index [2];
  state_t            dbg [2];

  conv_scheduler #(.MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .conv_done(done[0]), .conv_start(conv_start[0]), .mem_en(mem_en[0]),
    .a1(a[0][0]), .a2(a[0][1]), .a3(a[0][2]), .a4(a[0][3]), .a5(a[0][4]),
    .cur_index(cur_index[0]), .busy(busy[0]), .pass(pass[0]),
    .err_spurious(err[0]), .dbg_state(dbg[0])
  );

  conv_scheduler #(.MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .conv_done(done[1]), .conv_start(conv_start[1]), .mem_en(mem_en[1]),
    .a1(a[1][0]), .a2(a[1][1]), .a3(a[1][2]), .a4(a[1][3]), .a5(a[1][4]),
    .cur_index(cur_index[1]), .busy(busy[1]), .pass(pass[1]),
    .err_spurious(err[1]), .dbg_state(dbg[1])
  );

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;
  int exp_off  [NUM_BANKS] = '{0, 11520, 23040, 34560, 46080};
  int exp_last [NUM_BANKS] = '{11519, 23039, 34559, 46079, 57599};

  task automatic chk(input string nm, input int m, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d]: got %0d expected %0d", nm, m, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per pixel: t counts cycles since the read strobe. Strobe at t=0, engine
  // fire at t=LAT+1, waiting for done once t >= LAT+2.
  bit m_active [2];
  int m_idx    [2];
  int m_t      [2];
  bit m_pass   [2];
  bit m_err    [2];

  function automatic int lat_of(input int m);
    return (m == 0) ? LAT0 : LAT1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_active[m] = 0; m_idx[m] = 0; m_t[m] = 0; m_pass[m] = 0; m_err[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int  l;
    bit  d;
    l = lat_of(m);
    d = done[m];
    m_pass[m] = 0;
    if (d && !(m_active[m] && m_t[m] >= l + 2)) m_err[m] = 1;
    if (abort) begin
      m_active[m] = 0;
      m_idx[m]    = 0;
    end else if (!m_active[m]) begin
      if (start) begin
        m_active[m] = 1; m_idx[m] = 0; m_t[m] = 0;
      end
    end else if (m_t[m] >= l + 2) begin
      if (d) begin
        if (m_idx[m] == BANK_DEPTH - 1) begin
          m_active[m] = 0; m_idx[m] = 0; m_pass[m] = 1;
        end else begin
          m_idx[m] = m_idx[m] + 1; m_t[m] = 0;
        end
      end
    end else begin
      m_t[m] = m_t[m] + 1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else for (int m = 0; m < 2; m++) model_step(m);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        chk("busy", m, 32'(busy[m]), 32'(m_active[m]));
        chk("mem_en", m, 32'(mem_en[m]), 32'(m_active[m] && m_t[m] == 0));
        chk("conv_start", m, 32'(conv_start[m]),
            32'(m_active[m] && m_t[m] == lat_of(m) + 1));
        chk("cur_index", m, 32'(cur_index[m]), 32'(m_idx[m]));
        chk("pass", m, 32'(pass[m]), 32'(m_pass[m]));
        chk("err_spurious", m, 32'(err[m]), 32'(m_err[m]));
        for (int k = 0; k < NUM_BANKS; k++) begin
          chk("addr", m, 32'(a[m][k]), 32'(m_idx[m] + k * BANK_DEPTH));
        end
      end
    end
  end

  // ---------------- driver: engine model + tick ----------------
  bit eng_en  [2];
  int eng_cnt [2];
  int dmin = 2;
  int dmax = 2;
  int spur_pct = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (eng_en[m]) begin
        done[m] = 1'b0;
        if (eng_cnt[m] > 0) begin
          eng_cnt[m] = eng_cnt[m] - 1;
          if (eng_cnt[m] == 0) done[m] = 1'b1;
        end
        if (conv_start[m]) eng_cnt[m] = $urandom_range(dmax, dmin);
        if (spur_pct > 0 && $urandom_range(99, 0) < spur_pct) done[m] = 1'b1;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < NUM_BANKS; k++) chk({tag, "_addr"}, m, 32'(a[m][k]), 32'(exp_off[k]));
      chk({tag, "_mem_en"}, m, 32'(mem_en[m]), 0);
      chk({tag, "_conv_start"}, m, 32'(conv_start[m]), 0);
      chk({tag, "_busy"}, m, 32'(busy[m]), 0);
      chk({tag, "_pass"}, m, 32'(pass[m]), 0);
      chk({tag, "_err"}, m, 32'(err[m]), 0);
      chk({tag, "_index"}, m, 32'(cur_index[m]), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  int cs_cnt   [2];
  int pass_cnt [2];
  int last_a   [2][NUM_BANKS];
  bit found;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; done = 2'b00;
    eng_en = '{0, 0}; eng_cnt = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    cmp_en  = 1;
    reset_n = 1'b1;
    repeat (10) tick();
    check_reset_vals("idle10");

    // Single pixel, engine driven by hand.
    start = 1'b1; tick(); start = 1'b0;                     // T1
    chk("t1_mem_en", 0, 32'(mem_en[0]), 1);
    chk("t1_busy", 0, 32'(busy[0]), 1);
    chk("t1_mem_en", 1, 32'(mem_en[1]), 1);
    tick();                                                  // T2
    chk("t2_mem_en", 0, 32'(mem_en[0]), 0);
    chk("t2_lat0_fire", 1, 32'(conv_start[1]), 1);
    tick();                                                  // T3
    chk("t3_conv_start", 0, 32'(conv_start[0]), 1);
    chk("t3_state", 1, 32'(dbg[1]), 32'(WAIT_DONE));
    repeat (3) tick();                                       // T6
    done = 2'b11; tick(); done = 2'b00;                      // T7
    chk("t7_mem_en", 0, 32'(mem_en[0]), 1);
    chk("t7_a1", 0, 32'(a[0][0]), 1);
    chk("t7_a5", 0, 32'(a[0][4]), 46081);
    chk("t7_mem_en", 1, 32'(mem_en[1]), 1);
    chk("t7_a1", 1, 32'(a[1][0]), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idx", 0, 32'(cur_index[0]), 0);
    chk("abort_busy", 1, 32'(busy[1]), 0);

    // Spurious done in IDLE and WAIT_MEM; start while busy.
    done = 2'b11; tick(); done = 2'b00;
    chk("spur_idle", 0, 32'(err[0]), 1);
    chk("spur_idle", 1, 32'(err[1]), 1);
    tick();
    chk("spur_sticky", 0, 32'(err[0]), 1);
    start = 1'b1; tick(); start = 1'b0;                      // T1
    tick();                                                  // T2 WAIT_MEM
    done = 2'b01; tick(); done = 2'b00;                      // T3
    chk("spur_wm_fire", 0, 32'(conv_start[0]), 1);
    start = 1'b1; tick(); start = 1'b0;                      // T4
    chk("busy_start_state", 0, 32'(dbg[0]), 32'(WAIT_DONE));
    chk("busy_start_idx", 0, 32'(cur_index[0]), 0);
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort in WAIT_DONE at index 100 together with conv_done.
    eng_en = '{1, 1}; eng_cnt = '{0, 0}; dmin = 2; dmax = 2;
    start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (cur_index[0] == 100 && dbg[0] == WAIT_DONE) found = 1;
      else tick();
    end
    chk("timeout_idx100", 0, 32'(found), 1);
    eng_en[0] = 0; eng_cnt[0] = 0;
    done[0] = 1'b1; abort = 1'b1; tick(); abort = 1'b0; done[0] = 1'b0;
    chk("abort100_busy", 0, 32'(busy[0]), 0);
    chk("abort100_pass", 0, 32'(pass[0]), 0);
    chk("abort100_idx", 0, 32'(cur_index[0]), 0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_a1", 0, 32'(a[0][0]), 0);
    chk("restart_mem_en", 0, 32'(mem_en[0]), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    eng_en[0] = 1; eng_cnt = '{0, 0};

    // Asynchronous reset mid-FETCH at index 500.
    start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (cur_index[0] == 500 && mem_en[0]) found = 1;
      else tick();
    end
    chk("timeout_idx500", 0, 32'(found), 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    eng_cnt = '{0, 0}; done = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic.
    dmin = 1; dmax = 4; spur_pct = 2;
    repeat (3000) begin
      tick();
      start = ($urandom_range(3, 0) == 0);
      abort = ($urandom_range(199, 0) == 0);
    end
    spur_pct = 0; start = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (6) tick();

    // Full frame, engine answers 2 cycles after conv_start.
    dmin = 2; dmax = 2; eng_cnt = '{0, 0};
    cs_cnt = '{0, 0}; pass_cnt = '{0, 0};
    tick();
    start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int c = 0; c < 70000 && !found; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (conv_start[m]) begin
          cs_cnt[m]++;
          for (int k = 0; k < NUM_BANKS; k++) last_a[m][k] = int'(a[m][k]);
        end
        if (pass[m]) pass_cnt[m]++;
      end
      if (!busy[0] && !busy[1]) found = 1;
      else tick();
    end
    chk("timeout_frame", 0, 32'(found), 1);
    for (int m = 0; m < 2; m++) begin
      chk("frame_conv_starts", m, 32'(cs_cnt[m]), 11520);
      chk("frame_pass_count", m, 32'(pass_cnt[m]), 1);
      chk("frame_end_busy", m, 32'(busy[m]), 0);
      chk("frame_end_idx", m, 32'(cur_index[m]), 0);
      for (int k = 0; k < NUM_BANKS; k++) chk("frame_last_addr", m, 32'(last_a[m][k]), 32'(exp_last[k]));
    end
    tick();
    chk("pass_one_cycle", 0, 32'(pass[0]), 0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
